// File: rtl/layer7_pkg.sv
// layer7_pkg: shared constants and loader state type for the layer-7 weight path.
//   load_state_t      - weight loader FSM states (IDLE/LOAD/DONE)
//   LAYER7_WEIGHT_NUM - weights per layer-7 load; also sizes the weight memory
//   LAYER7_WEIGHT_W   - width of one weight
package layer7_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_t;

    localparam int LAYER7_WEIGHT_NUM = 2000;
    localparam int LAYER7_WEIGHT_W   = 16;

endpackage

// File: rtl/layer7_weight_loader.sv
// layer7_weight_loader: unpacks a stream of two-weight bus words into sequential single-weight memory writes.
// Ports:
//   clk, rst            - clock; asynchronous active-high reset (aborts any load in progress)
//   start               - begin a load of WEIGHT_NUM weights (honoured only in IDLE)
//   in_valid, in_data   - source word; [DATA_W-1:0] is weight n, upper half is weight n+1
//   in_ready            - word accepted on in_valid && in_ready
//   write_weight_signal - one-cycle write strobe per weight
//   write_weight_addr   - write address (held when strobe low)
//   write_weight_data   - write data (held when strobe low)
//   busy                - load in progress
//   done                - one-cycle pulse after the final weight write
module layer7_weight_loader
    import layer7_pkg::*;
#(
    parameter int WEIGHT_NUM = LAYER7_WEIGHT_NUM,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = LAYER7_WEIGHT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [2*DATA_W-1:0] in_data,
    output logic                in_ready,
    output logic                write_weight_signal,
    output logic [ADDR_W-1:0]   write_weight_addr,
    output logic [DATA_W-1:0]   write_weight_data,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] TOTAL = ADDR_W'(WEIGHT_NUM);

    load_state_t       state, state_nx;
    logic              phase, phase_nx;
    logic              wr_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx, cnt_inc, addr_nx;
    logic [DATA_W-1:0] hi_buf, hi_nx, data_nx;

    assign cnt_inc  = cnt + 1'b1;
    assign in_ready = (state == LOAD) && !phase;
    assign busy     = state == LOAD;
    assign done     = state == DONE;

    // cnt is the address of the next write; reaching TOTAL means every weight
    // is written. The phase-1 slot that follows the final write (either a
    // discarded odd high half or a forced extra phase-1 cycle) moves to DONE,
    // which keeps in_ready low and places done one cycle after that write.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        cnt_nx   = cnt;
        hi_nx    = hi_buf;
        wr_nx    = 1'b0;
        addr_nx  = write_weight_addr;
        data_nx  = write_weight_data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    phase_nx = 1'b0;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                if (phase) begin
                    if (cnt == TOTAL) begin
                        state_nx = DONE;
                        phase_nx = 1'b0;
                    end else begin
                        wr_nx    = 1'b1;
                        addr_nx  = cnt;
                        data_nx  = hi_buf;
                        cnt_nx   = cnt_inc;
                        phase_nx = cnt_inc == TOTAL;
                    end
                end else if (in_valid) begin
                    wr_nx    = 1'b1;
                    addr_nx  = cnt;
                    data_nx  = in_data[DATA_W-1:0];
                    hi_nx    = in_data[2*DATA_W-1:DATA_W];
                    cnt_nx   = cnt_inc;
                    phase_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                phase_nx = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                phase_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            phase               <= 1'b0;
            cnt                 <= '0;
            hi_buf              <= '0;
            write_weight_signal <= 1'b0;
            write_weight_addr   <= '0;
            write_weight_data   <= '0;
        end else begin
            state               <= state_nx;
            phase               <= phase_nx;
            cnt                 <= cnt_nx;
            hi_buf              <= hi_nx;
            write_weight_signal <= wr_nx;
            write_weight_addr   <= addr_nx;
            write_weight_data   <= data_nx;
        end
    end

endmodule

// File: tb/tb_layer7_weight_loader.sv
// tb_layer7_weight_loader: self-checking bench for layer7_weight_loader with 8- and 5-weight instances.
module tb_layer7_weight_loader;

    typedef struct {
        bit          sel5;
        logic [31:0] word;
        logic [15:0] a0, d0, a1, d1;
        bit          hi;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start8, start5, in_valid;
    logic [31:0] in_data;
    logic        rdy8, ws8, busy8, done8, rdy5, ws5, busy5, done5;
    logic [15:0] wa8, wd8, wa5, wd5;

    int checks = 0, fails = 0, cyc = 0;
    int strobes8 = 0, dones8 = 0, lastwr8 = 0;
    int strobes5 = 0, dones5 = 0, lastwr5 = 0;
    logic [15:0] qa8[$], qd8[$], qa5[$], qd5[$];
    vec_t tbl[7];

    layer7_weight_loader #(.WEIGHT_NUM(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy8), .write_weight_signal(ws8), .write_weight_addr(wa8),
        .write_weight_data(wd8), .busy(busy8), .done(done8)
    );

    layer7_weight_loader #(.WEIGHT_NUM(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy5), .write_weight_signal(ws5), .write_weight_addr(wa5),
        .write_weight_data(wd5), .busy(busy5), .done(done5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s timed out", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ws8) begin
                strobes8++;
                lastwr8 = cyc;
                if (qa8.size() == 0) check("dut8 unexpected write", ws8, 0);
                else begin
                    check("dut8 addr", wa8, qa8.pop_front());
                    check("dut8 data", wd8, qd8.pop_front());
                end
            end
            if (done8) begin
                dones8++;
                check("dut8 done latency", cyc - lastwr8, 1);
                check("dut8 busy at done", busy8, 0);
            end
            if (ws5) begin
                strobes5++;
                lastwr5 = cyc;
                if (qa5.size() == 0) check("dut5 unexpected write", ws5, 0);
                else begin
                    check("dut5 addr", wa5, qa5.pop_front());
                    check("dut5 data", wd5, qd5.pop_front());
                end
            end
            if (done5) begin
                dones5++;
                check("dut5 done latency", cyc - lastwr5, 1);
                check("dut5 busy at done", busy5, 0);
            end
        end
    end

    task automatic do_start(input bit sel5);
        strobes8 = 0; dones8 = 0; strobes5 = 0; dones5 = 0;
        if (sel5) start5 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        start8 = 1'b0;
        check("busy after start", sel5 ? busy5 : busy8, 1);
        check("in_ready after start", sel5 ? rdy5 : rdy8, 1);
    endtask

    task automatic send(input vec_t v, input bit gaps);
        in_data  = v.word;
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (in_valid && (v.sel5 ? rdy5 : rdy8)) begin
                @(posedge clk);
                if (v.sel5) begin
                    qa5.push_back(v.a0); qd5.push_back(v.d0);
                    if (v.hi) begin qa5.push_back(v.a1); qd5.push_back(v.d1); end
                end else begin
                    qa8.push_back(v.a0); qd8.push_back(v.d0);
                    if (v.hi) begin qa8.push_back(v.a1); qd8.push_back(v.d1); end
                end
                @(negedge clk);
                in_valid = 1'b0;
                check("in_ready low after accept", v.sel5 ? rdy5 : rdy8, 0);
                return;
            end
            @(negedge clk);
            if (gaps) in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        timeout("handshake");
    endtask

    task automatic wait_done(input bit sel5, input int nwr);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if ((sel5 ? dones5 : dones8) != 0) break;
        end
        if (k == 100) timeout("done");
        repeat (3) @(negedge clk);
        #1;
        check("done count", sel5 ? dones5 : dones8, 1);
        check("strobe count", sel5 ? strobes5 : strobes8, nwr);
        check("queue drained", sel5 ? qa5.size() : qa8.size(), 0);
        check("idle after done", sel5 ? busy5 : busy8, 0);
    endtask

    initial begin
        tbl[0] = '{0, 32'h0002_0001, 16'd0, 16'h0001, 16'd1, 16'h0002, 1};
        tbl[1] = '{0, 32'h0004_0003, 16'd2, 16'h0003, 16'd3, 16'h0004, 1};
        tbl[2] = '{0, 32'h0006_0005, 16'd4, 16'h0005, 16'd5, 16'h0006, 1};
        tbl[3] = '{0, 32'h0008_0007, 16'd6, 16'h0007, 16'd7, 16'h0008, 1};
        tbl[4] = '{1, 32'hBBBB_AAAA, 16'd0, 16'hAAAA, 16'd1, 16'hBBBB, 1};
        tbl[5] = '{1, 32'hDDDD_CCCC, 16'd2, 16'hCCCC, 16'd3, 16'hDDDD, 1};
        tbl[6] = '{1, 32'hFFFF_EEEE, 16'd4, 16'hEEEE, 16'd0, 16'hFFFF, 0};

        rst = 1'b1; start8 = 1'b0; start5 = 1'b0; in_valid = 1'b0; in_data = '0;
        #3;
        check("reset in_ready", rdy8, 0);
        check("reset strobe", ws8, 0);
        check("reset addr", wa8, 0);
        check("reset data", wd8, 0);
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        check("reset dut5 in_ready", rdy5, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back, even total
        do_start(0);
        for (int i = 0; i < 4; i++) send(tbl[i], 0);
        wait_done(0, 8);

        // odd total: high half of the last word is dropped
        do_start(1);
        for (int i = 4; i < 7; i++) send(tbl[i], 0);
        wait_done(1, 5);

        // random valid gaps
        do_start(0);
        for (int i = 0; i < 4; i++) send(tbl[i], 1);
        wait_done(0, 8);

        // start re-pulsed in LOAD and in DONE
        do_start(0);
        send(tbl[0], 0);
        send(tbl[1], 0);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        send(tbl[2], 0);
        send(tbl[3], 0);
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                if (done8) break;
                @(negedge clk);
            end
            if (k == 50) timeout("done for restart test");
        end
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("start in DONE ignored", busy8, 0);
        repeat (3) @(negedge clk);
        #1;
        check("single done", dones8, 1);
        check("strobes with restarts", strobes8, 8);
        check("queue drained restarts", qa8.size(), 0);

        // reset after three writes
        do_start(0);
        send(tbl[0], 0);
        in_data = 32'h0004_0003;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready before third write", rdy8, 1);
        @(posedge clk);
        qa8.push_back(16'd2);
        qd8.push_back(16'h0003);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst strobe", ws8, 0);
        check("rst addr", wa8, 0);
        check("rst data", wd8, 0);
        check("rst busy", busy8, 0);
        check("rst in_ready", rdy8, 0);
        check("rst done", done8, 0);
        check("writes before rst", strobes8, 3);
        check("queue before rst", qa8.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(0);
        send('{0, 32'h0202_0101, 16'd0, 16'h0101, 16'd1, 16'h0202, 1}, 0);
        repeat (2) @(negedge clk);
        #1;
        check("writes after restart", strobes8, 2);
        check("queue after restart", qa8.size(), 0);
        check("no done after restart", dones8, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // valid held in IDLE without start
        strobes8 = 0; strobes5 = 0;
        in_valid = 1'b1;
        in_data = 32'h1234_5678;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle in_ready dut8", rdy8, 0);
            check("idle in_ready dut5", rdy5, 0);
        end
        #1;
        check("idle writes dut8", strobes8, 0);
        check("idle writes dut5", strobes5, 0);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
